// File: rtl/current_limiter.sv
// current_limiter: conditions the raw over-current comparator for the 8-bit
// PWM channel. Synchronises and glitch-filters ocin, blanks the first
// BLANK_COUNTS counts of each PWM cycle, and latches a cycle-by-cycle limit
// that holds until the next cycle start.
// Optional build macro CURRENT_FAULT_LATCH_EN adds escalation: FAULT_CYCLES
// consecutive limited cycles latch a fault that forces the limit on until
// faultclr. Without the macro, fault is tied low and faultclr is ignored.
module current_limiter #(
  parameter int FILTER_LEN   = 3,
  parameter int BLANK_COUNTS = 4,
  parameter int FAULT_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ocin,
  input  logic       pwmcntce,
  input  logic [7:0] pwmcount,
  input  logic       faultclr,
  output logic       currentlimit,
  output logic       fault,
  output logic       ocstatus
);

  localparam logic [3:0] FLT_MAX   = 4'(FILTER_LEN);
  localparam logic [7:0] BLANK_LIM = 8'(BLANK_COUNTS);

  logic [1:0] r_sync;
  logic [3:0] r_fcnt;
  logic       r_limreg;

  logic w_ocsync;
  logic w_ocfilt;
  logic w_cyclestart;
  logic w_blank;
  logic w_limset;

  assign w_ocsync     = r_sync[1];
  assign w_ocfilt     = (r_fcnt == FLT_MAX);
  // The counter wraps 255 -> 0 on this clk, so this is where a new cycle begins.
  assign w_cyclestart = pwmcntce && (pwmcount == 8'hFF);
  assign w_blank      = (pwmcount < BLANK_LIM);
  assign w_limset     = w_ocfilt && !w_blank;
  assign ocstatus     = w_ocfilt;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], ocin};
  end

  // Saturating glitch filter; any low sample restarts qualification.
  always_ff @(posedge clk) begin
    if (reset)                r_fcnt <= 4'd0;
    else if (!w_ocsync)       r_fcnt <= 4'd0;
    else if (r_fcnt != FLT_MAX) r_fcnt <= r_fcnt + 4'd1;
  end

  // Cycle-by-cycle limit latch; a cycle start clears it even if a set is pending.
  always_ff @(posedge clk) begin
    if (reset)             r_limreg <= 1'b0;
    else if (w_cyclestart) r_limreg <= 1'b0;
    else if (w_limset)     r_limreg <= 1'b1;
  end

`ifdef CURRENT_FAULT_LATCH_EN
  localparam logic [7:0] FAULT_MAX = 8'(FAULT_CYCLES);

  typedef enum logic {NORMAL = 1'b0, FAULT = 1'b1} state_t;

  state_t     r_state;
  logic       r_tripped;
  logic [7:0] r_consec;

  // Fault escalation: count consecutive limited cycles, latch FAULT at the
  // threshold, and release (restarting the count) only on faultclr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= NORMAL;
      r_tripped <= 1'b0;
      r_consec  <= 8'd0;
    end else begin
      if (w_cyclestart) begin
        r_tripped <= 1'b0;
        if (!r_tripped)                r_consec <= 8'd0;
        else if (r_consec != FAULT_MAX) r_consec <= r_consec + 8'd1;
      end else if (w_limset) begin
        r_tripped <= 1'b1;
      end
      case (r_state)
        NORMAL: if (r_consec == FAULT_MAX) r_state <= FAULT;
        FAULT: begin
          if (faultclr) begin
            r_state   <= NORMAL;
            r_consec  <= 8'd0;
            r_tripped <= 1'b0;
          end
        end
        default: r_state <= NORMAL;
      endcase
    end
  end

  assign fault        = (r_state == FAULT);
  assign currentlimit = r_limreg | fault;
`else
  logic w_unused_faultclr;
  assign w_unused_faultclr = faultclr;
  assign fault             = 1'b0;
  assign currentlimit      = r_limreg;
`endif

endmodule
